// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift sequencer: register opcodes and controller states.
// Optional build macro used by the controller: SHIFT_SEQ_ROTATE_EN.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Job handshake, serial stream and status bundle between a job source and shift_seq_ctrl.
interface shift_seq_ctrl_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) ();
  logic          start_valid;
  logic          start_ready;
  logic [N-1:0]  data_in;
  logic          dir;
  logic [CW-1:0] len;
  logic          stall;
  logic          ser_in;
  logic          ser_out;
  logic          ser_valid;
  logic [N-1:0]  q_out;
  logic          done;

  modport master (
    output start_valid, data_in, dir, len, stall, ser_in,
    input  start_ready, ser_out, ser_valid, q_out, done
  );

  modport slave (
    input  start_valid, data_in, dir, len, stall, ser_in,
    output start_ready, ser_out, ser_valid, q_out, done
  );
endinterface

// File: rtl/shift_seq_ctrl_shiftreg_op.sv
// N-bit register with hold / shift-left / shift-right / parallel-load opcodes.
// Has no reset by design; contents are unknown until the first load.
module shiftreg_op
  import shift_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         enable,
  input  logic [1:0]   OP,
  input  logic [N-1:0] d,
  input  logic         shift_in,
  output logic [N-1:0] q,
  output logic         shift_out_left,
  output logic         shift_out_right
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    unique case (op_e'(OP))
      OP_HOLD: q_d = q_q;
      OP_SHL:  q_d = {q_q[N-2:0], shift_in};
      OP_SHR:  q_d = {shift_in, q_q[N-1:1]};
      OP_LOAD: q_d = d;
      default: q_d = q_q;
    endcase
  end

  // enable is wired to the system clock by the owner, so it acts as the clock here
  always_ff @(posedge enable) begin
    q_q <= q_d;
  end

  assign q               = q_q;
  assign shift_out_left  = q_q[N-1];
  assign shift_out_right = q_q[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load-then-shift sequencer around shiftreg_op, streaming each outgoing bit.
// Build macro SHIFT_SEQ_ROTATE_EN: feed the outgoing bit back in (rotate) instead of ser_in.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  shift_seq_ctrl_if.slave bus
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  word_q, word_d;
  logic          dir_q, dir_d;

  op_e           op;
  logic          start_ready;
  logic          done;
  logic          ser_valid;
  logic          ser_bit;
  logic          shift_in;
  logic [N-1:0]  q;
  logic          shift_out_left;
  logic          shift_out_right;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          word_d  = bus.data_in;
          dir_d   = bus.dir;
          cnt_d   = (bus.len > CW'(N)) ? CW'(N) : bus.len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = (cnt_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        // SHIFT is only entered with a non-zero count, so reaching 1 means last shift
        if (!bus.stall) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    op          = OP_HOLD;
    start_ready = 1'b0;
    done        = 1'b0;
    ser_valid   = 1'b0;
    unique case (state_q)
      IDLE:    start_ready = 1'b1;
      LOAD:    op = OP_LOAD;
      SHIFT: begin
        if (!bus.stall) begin
          op        = dir_q ? OP_SHR : OP_SHL;
          ser_valid = 1'b1;
        end
      end
      DONE:    done = 1'b1;
      default: op = OP_HOLD;
    endcase
  end

  assign ser_bit = dir_q ? shift_out_right : shift_out_left;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic unused_ser_in;
  assign unused_ser_in = bus.ser_in;
  assign shift_in      = ser_bit;
`else
  assign shift_in      = bus.ser_in;
`endif

  shiftreg_op #(.N(N)) u_shiftreg (
    .enable          (clk),
    .OP              (op),
    .d               (word_q),
    .shift_in        (shift_in),
    .q               (q),
    .shift_out_left  (shift_out_left),
    .shift_out_right (shift_out_right)
  );

  assign bus.start_ready = start_ready;
  assign bus.done        = done;
  assign bus.ser_valid   = ser_valid;
  assign bus.ser_out     = ser_bit;
  assign bus.q_out       = q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: driver models each job and queues expectations,
// a negedge monitor pops and compares them. Honours SHIFT_SEQ_ROTATE_EN like the RTL.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int N    = 4;
  localparam int CW   = $clog2(N + 1);
  localparam int MAXC = 40;

  typedef struct {
    int           cyc;
    logic [N-1:0] q;
  } stamp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.N(N), .CW(CW)) bus ();

  shift_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  bit     mon_en = 1'b0;
  stamp_t exp_done[$];
  stamp_t exp_q[$];
  bit     exp_bits[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every queued expectation is consumed when the DUT presents it.
  always @(negedge clk) begin : monitor
    stamp_t s;
    if (mon_en && !rst) begin
      check("start_ready", 32'(bus.start_ready), 32'(exp_done.size() == 0));
      if (bus.stall) check("ser_valid_while_stall", 32'(bus.ser_valid), 0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        s = exp_q.pop_front();
        check("q_out", 32'(bus.q_out), 32'(s.q));
      end
      if (bus.ser_valid) begin
        if (exp_bits.size() == 0) check("unexpected_ser_valid", 1, 0);
        else check("ser_out", 32'(bus.ser_out), 32'(exp_bits.pop_front()));
      end
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          s = exp_done.pop_front();
          check("done_cycle", 32'(cyc), 32'(s.cyc));
          check("q_at_done", 32'(bus.q_out), 32'(s.q));
          check("bits_left_at_done", 32'(exp_bits.size()), 0);
        end
      end
    end
  end

  task automatic do_reset(input logic [N-1:0] q_frozen);
    mon_en = 1'b0;
    exp_done.delete();
    exp_q.delete();
    exp_bits.delete();
    bus.start_valid = 1'b0;
    bus.stall       = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_op_hold", 32'(dut.op), 32'(OP_HOLD));
    check("rst_start_ready", 32'(bus.start_ready), 1);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ser_valid", 32'(bus.ser_valid), 0);
    check("rst_q_frozen", 32'(bus.q_out), 32'(q_frozen));
    @(posedge clk);
    #1;
    check("rst_q_held_over_edge", 32'(bus.q_out), 32'(q_frozen));
    rst    = 1'b0;
    mon_en = 1'b1;
    $display("RESET mid-job q_out=%b", bus.q_out);
  endtask

  // abort_at = relative cycle in which reset is applied (0 = run to completion)
  task automatic run_job(input logic [N-1:0] data, input logic d, input logic [CW-1:0] len,
                         input bit [MAXC-1:0] stall_v, input bit [MAXC-1:0] sin_v,
                         input int abort_at);
    int           nshift;
    int           i;
    int           n;
    int           acc;
    int           t;
    bit           b;
    bit           s;
    bit           bq[$];
    logic [N-1:0] q;
    logic [N-1:0] qat[MAXC];

    // Reference: walk relative cycles; shifts happen from cycle 2 on, skipping stalled ones.
    nshift = (int'(len) > N) ? N : int'(len);
    q = data;
    i = 2;
    n = 0;
    while (n < nshift && i < MAXC - 1) begin
      qat[i] = q;
      if (!stall_v[i]) begin
        b = d ? q[0] : q[N-1];
        bq.push_back(b);
`ifdef SHIFT_SEQ_ROTATE_EN
        s = b;
`else
        s = sin_v[i];
`endif
        if (d) q = (q >> 1) | (N'(s) << (N - 1));
        else   q = (q << 1) | N'(s);
        n++;
      end
      i++;
    end
    qat[i] = q;

    t = 0;
    while (!bus.start_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.start_ready) check("wait_start_ready_timeout", 0, 1);

    bus.data_in     = data;
    bus.dir         = d;
    bus.len         = len;
    bus.stall       = stall_v[0];
    bus.ser_in      = sin_v[0];
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    exp_done.push_back('{acc + i - 1, q});
    for (int j = 2; j <= i; j++) exp_q.push_back('{acc + j - 1, qat[j]});
    foreach (bq[k]) exp_bits.push_back(bq[k]);

    for (int j = 1; j <= i; j++) begin
      if (j == abort_at) begin
        do_reset(qat[j]);
        return;
      end
      bus.stall       = stall_v[j];
      bus.ser_in      = sin_v[j];
      bus.start_valid = 1'($urandom_range(0, 1));
      bus.data_in     = N'($urandom);
      bus.dir         = 1'($urandom_range(0, 1));
      bus.len         = CW'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start_valid = 1'b0;
    bus.stall       = 1'b0;

    t = 0;
    while (exp_done.size() > 0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_done.size() > 0) begin
      check("done_timeout", 0, 1);
      exp_done.delete();
      exp_q.delete();
      exp_bits.delete();
    end
    $display("JOB data=%b dir=%0d len=%0d shifts=%0d latency=%0d final_q=%b",
             data, d, len, nshift, i, q);
  endtask

  initial begin
    bit [MAXC-1:0] st;
    bit [MAXC-1:0] si;

    bus.start_valid = 1'b0;
    bus.data_in     = '0;
    bus.dir         = 1'b0;
    bus.len         = '0;
    bus.stall       = 1'b0;
    bus.ser_in      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_start_ready", 32'(bus.start_ready), 1);
    check("reset_done", 32'(bus.done), 0);
    check("reset_ser_valid", 32'(bus.ser_valid), 0);
    check("reset_op", 32'(dut.op), 32'(OP_HOLD));
    rst    = 1'b0;
    mon_en = 1'b1;

    run_job(4'b1010, 1'b1, 3'd4, '0, '0, 0);
    run_job(4'b1010, 1'b0, 3'd2, '0, '0, 0);
    st = '0;
    st[3] = 1'b1;
    st[4] = 1'b1;
    run_job(4'b1111, 1'b0, 3'd4, st, '0, 0);
    run_job(4'b0110, 1'b0, 3'd0, '1, '1, 0);
    run_job(4'b1001, 1'b1, 3'd7, '0, '1, 0);
    run_job(4'b1010, 1'b1, 3'd4, '0, '0, 4);
    run_job(4'b0011, 1'b0, 3'd3, '0, '1, 0);

    for (int r = 0; r < 40; r++) begin
      st = '0;
      si = '0;
      for (int j = 0; j < MAXC; j++) begin
        if (j < 20) st[j] = ($urandom_range(0, 2) == 0);
        si[j] = 1'($urandom_range(0, 1));
      end
      run_job(N'($urandom), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 7)), st, si,
              ($urandom_range(0, 9) == 0) ? 3 : 0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer that owns one `shiftreg_op` instance and drives its `OP`, `d` and `shift_in` inputs. It accepts a parallel word through a valid/ready handshake, loads it, and performs a programmed number of left or right shifts, presenting each outgoing bit as a qualified serial stream. It is the first serializer/deserializer building block in the practice datapath.

## Interface
- `N`, 4: register width; also the maximum shift count.
- `CW`, `$clog2(N+1)`: width of the shift-count field.

Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; also drives `shiftreg_op.enable`.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  request carries a job.
- `start_ready`  out  1  controller can accept a job (IDLE only).
- `data_in`  in  N  word to load; sampled at the accept edge.
- `dir`  in  1  0 = left (`OP`=01), 1 = right (`OP`=10); sampled at the accept edge.
- `len`  in  CW  number of shifts; sampled at the accept edge; values above N clamp to N.
- `stall`  in  1  when high in SHIFT, drive `OP`=00 (hold); the count does not advance.
- `ser_in`  in  1  serial bit fed to `shift_in`.
- `ser_out`  out  1  outgoing bit of the shift at the next edge.
- `ser_valid`  out  1  `ser_out` is consumed at the next edge.
- `q_out`  out  N  live register contents (`q`).
- `done`  out  1  one-cycle pulse after the final shift.

## Operation
- States:
  - IDLE: `start_ready`=1; `OP`=00. On `start_valid`, latch `data_in`, `dir` and clamped `len`, then go to LOAD.
  - LOAD: `OP`=11 and `d`=latched word for exactly one cycle. Go to SHIFT if `len`>0, else to DONE.
  - SHIFT: `OP`=01/10 per `dir` when `!stall`, else 00. The remaining-count register decrements on each non-stalled edge. Go to DONE when the count reaches 0.
  - DONE: `done`=1 for one cycle, `OP`=00, then go to IDLE.
- `ser_out`:
  - Equals `shift_out_left` (`q[N-1]`) when `dir`=0, and `shift_out_right` (`q[0]`) when `dir`=1.
  - `ser_valid` = (state==SHIFT && !stall).
- `start_valid` outside IDLE is ignored; the job is not queued.
- The `d` mux drives the latched word in all states. The register only loads in LOAD.
- Reset (including mid-job):
  - State goes to IDLE and the count to 0.
  - `OP` goes to 00 immediately (combinational from state).
  - Outputs: `start_ready`=1, `done`=0, `ser_valid`=0, `ser_out` follows `q`.
  - `shiftreg_op` has no reset, so `q_out` holds its last value (unknown before the first load).

## Timing
- Accept at edge k. The register loads at edge k+1.
- Shifts occur on edges k+2 … k+1+`len`, plus one additional edge for each stalled cycle.
- `done` is high in the cycle following the last shift edge. `q_out` is final in that cycle.
- `start_ready` returns one cycle after `done`.
- Minimum job (`len`=0) is 3 cycles, accept to IDLE.
- `stall` is sampled every SHIFT cycle. It has no effect in other states.

## Configuration
- `SHIFT_SEQ_ROTATE_EN`:
  - Defined: `shift_in` = the outgoing bit (`ser_out`), so the register rotates and `ser_in` is ignored.
  - Undefined: `shift_in` = `ser_in`.

## Structure
- Package `shift_seq_pkg`:
  - `op_e` (`OP_HOLD`=2'b00, `OP_SHL`=2'b01, `OP_SHR`=2'b10, `OP_LOAD`=2'b11).
  - `state_e` (IDLE, LOAD, SHIFT, DONE).
- Sub-module: the existing `shiftreg_op #(N)`, with `enable` tied to `clk`.
- The controller itself is a single always_ff FSM plus counter, with a combinational `OP`/`ser_out` decode.

## Test plan
- N=4, `data_in`=1010, `dir`=1, `len`=4, `ser_in`=0 → `ser_out` sequence 0,1,0,1 with `ser_valid` high for 4 cycles; `q_out`=0000 at `done`.
- `data_in`=1010, `dir`=0, `len`=2 → `ser_out` 1,0; `q_out`=1000 at `done`; `done` exactly one cycle.
- `data_in`=1111, `dir`=0, `len`=4, `stall` high for 2 cycles after the first shift → `q_out` holds 1110 during the stall; `ser_valid` is 0 while stalled; `done` is 2 cycles later than the unstalled case; final `q_out`=0000.
- `len`=0 with `data_in`=0110 → `q_out`=0110, `done` 2 cycles after accept, no `ser_valid`; `len`=7 clamps to 4 shifts.
- `rst` asserted after the second shift of a right job → immediate IDLE, `OP`=00, `start_ready`=1, `q_out` frozen; the next job runs normally.
- `SHIFT_SEQ_ROTATE_EN` defined, `data_in`=1010, `dir`=1, `len`=4 → `ser_out` 0,1,0,1; `q_out`=1010 at `done` regardless of `ser_in`.
